// File: rtl/periph_timer.sv
// Memory-mapped 16-bit timer (CTL/TAR/CCR0) on the MAB/MDB bus with prescaler and IRQ.
// Optional feature macro: PERIPH_TIMER_UPDOWN_EN enables MC=11 up/down counting.
module periph_timer #(
  parameter logic [15:0] BASE = 16'h0160
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] MAB_in,
  input  logic [15:0] MDB_in,
  input  logic        MW,
  input  logic        BW,
  output logic [15:0] MDB_periph,
  output logic        periph_sel,
  output logic        TA_IRQ
);

  localparam int unsigned DW = 16;
  localparam int unsigned PW = 3;
  localparam logic [DW-1:0] ADDR_TAR = BASE + 16'd2;
  localparam logic [DW-1:0] ADDR_CCR = BASE + 16'd4;
  localparam logic [DW-1:0] MAX_CNT  = 16'hFFFF;

  logic          ifg, ie;
  logic [1:0]    mc, id;
  logic [DW-1:0] tar, ccr0;
  logic [PW-1:0] presc;

  logic hit_ctl, hit_tar, hit_ccr;
  logic ctl_wr, tar_wr, ccr_wr, clr;
  logic running, tick, tick_eff;
  logic [PW-1:0] div_m1;
  logic [DW-1:0] tar_n, word_rd;
  logic          ifg_set;
`ifdef PERIPH_TIMER_UPDOWN_EN
  logic dir_down, dir_n;
`endif

  // Byte writes carry the byte in MDB_in[7:0] and land on the lane picked by the address LSB
  function automatic logic [DW-1:0] merge(input logic [DW-1:0] cur, input logic [DW-1:0] data,
                                          input logic bw, input logic hi);
    if (!bw)     return data;
    else if (hi) return {data[7:0], cur[7:0]};
    else         return {cur[15:8], data[7:0]};
  endfunction

  assign hit_ctl    = (MAB_in[15:1] == BASE[15:1]);
  assign hit_tar    = (MAB_in[15:1] == ADDR_TAR[15:1]);
  assign hit_ccr    = (MAB_in[15:1] == ADDR_CCR[15:1]);
  assign periph_sel = hit_ctl | hit_tar | hit_ccr;

  assign ctl_wr = MW & hit_ctl & (!BW | !MAB_in[0]);
  assign tar_wr = MW & hit_tar;
  assign ccr_wr = MW & hit_ccr;
  assign clr    = ctl_wr & MDB_in[2];

  // Read mux: addressed byte is zero-extended on byte reads
  always_comb begin
    word_rd = '0;
    if (hit_ctl)      word_rd = {8'h00, id, mc, 1'b0, 1'b0, ie, ifg};
    else if (hit_tar) word_rd = tar;
    else if (hit_ccr) word_rd = ccr0;
    if (BW) MDB_periph = MAB_in[0] ? {8'h00, word_rd[15:8]} : {8'h00, word_rd[7:0]};
    else    MDB_periph = word_rd;
  end

  assign TA_IRQ = ie & ifg;

  always_comb begin
    running = (mc == 2'b01) || (mc == 2'b10);
`ifdef PERIPH_TIMER_UPDOWN_EN
    running = running || (mc == 2'b11);
`endif
    case (id)
      2'd0:    div_m1 = 3'd0;
      2'd1:    div_m1 = 3'd1;
      2'd2:    div_m1 = 3'd3;
      default: div_m1 = 3'd7;
    endcase
  end

  assign tick     = running && (presc == div_m1);
  assign tick_eff = tick & !tar_wr & !clr;

  // Next counter value for a tick, per counting mode
  always_comb begin
    tar_n   = tar;
    ifg_set = 1'b0;
`ifdef PERIPH_TIMER_UPDOWN_EN
    dir_n   = dir_down;
`endif
    if (tick_eff) begin
      case (mc)
        2'b01: begin
          if (ccr0 == '0) tar_n = '0;
          else if (tar == ccr0 || tar == MAX_CNT) begin
            tar_n   = '0;
            ifg_set = 1'b1;
          end else tar_n = tar + 16'd1;
        end
        2'b10: begin
          tar_n   = tar + 16'd1;
          ifg_set = (tar == MAX_CNT);
        end
`ifdef PERIPH_TIMER_UPDOWN_EN
        2'b11: begin
          if (ccr0 == '0) begin
            tar_n = '0;
            dir_n = 1'b0;
          end else if (!dir_down) begin
            if (tar >= ccr0) begin
              dir_n = 1'b1;
              tar_n = tar - 16'd1;
            end else tar_n = tar + 16'd1;
          end else if (tar == 16'd1) begin
            tar_n   = '0;
            ifg_set = 1'b1;
          end else if (tar == '0) begin
            dir_n = 1'b0;
            tar_n = 16'd1;
          end else tar_n = tar - 16'd1;
        end
`endif
        default: tar_n = tar;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ifg   <= 1'b0;
      ie    <= 1'b0;
      mc    <= 2'b00;
      id    <= 2'b00;
      tar   <= '0;
      ccr0  <= '0;
      presc <= '0;
    end else begin
      if (ctl_wr) begin
        ie <= MDB_in[1];
        mc <= MDB_in[5:4];
        id <= MDB_in[7:6];
      end
      // Hardware IFG set beats a concurrent software clear
      if (ifg_set)     ifg <= 1'b1;
      else if (ctl_wr) ifg <= MDB_in[0];
      if (clr)         tar <= '0;
      else if (tar_wr) tar <= merge(tar, MDB_in, BW, MAB_in[0]);
      else             tar <= tar_n;
      if (ccr_wr) ccr0 <= merge(ccr0, MDB_in, BW, MAB_in[0]);
      if (tar_wr || clr || !running || tick) presc <= '0;
      else                                   presc <= presc + 3'd1;
    end
  end

`ifdef PERIPH_TIMER_UPDOWN_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        dir_down <= 1'b0;
    else if (clr)    dir_down <= 1'b0;
    else if (!tar_wr) dir_down <= dir_n;
  end
`endif

endmodule

// File: tb/tb_periph_timer.sv
// Directed self-checking bench for periph_timer.
module tb_periph_timer;
  localparam logic [15:0] A_CTL = 16'h0160;
  localparam logic [15:0] A_TAR = 16'h0162;
  localparam logic [15:0] A_CCR = 16'h0164;

  logic        clk, rst, MW, BW;
  logic [15:0] MAB_in, MDB_in, MDB_periph;
  logic        periph_sel, TA_IRQ;
  int errors, checks;
  logic [15:0] rv;

  periph_timer #(.BASE(16'h0160)) dut (
    .clk(clk), .rst(rst), .MAB_in(MAB_in), .MDB_in(MDB_in), .MW(MW), .BW(BW),
    .MDB_periph(MDB_periph), .periph_sel(periph_sel), .TA_IRQ(TA_IRQ)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [15:0] d, input logic bw);
    MAB_in = a; MDB_in = d; BW = bw; MW = 1'b1;
    @(posedge clk);
    #1;
    MW = 1'b0; BW = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, input logic bw, output logic [15:0] d);
    MAB_in = a; BW = bw;
    #1;
    d = MDB_periph;
    BW = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0; MW = 1'b0; BW = 1'b0; MAB_in = 16'h0; MDB_in = 16'h0;
    step(2);
    rst = 1'b1;
    step(1);
    bus_wr(A_TAR, 16'h1234, 1'b0);
    bus_wr(A_CTL, 16'h0022, 1'b0);
    step(3);
    rd(A_TAR, 1'b0, rv);
    checks++; if (rv !== 16'h1237) begin errors++; $display("FAIL reset_precount got=%h exp=1237", rv); end
    rst = 1'b0;
    rd(A_CTL, 1'b0, rv);
    checks++; if (rv !== 16'h0000) begin errors++; $display("FAIL reset_ctl got=%h exp=0000", rv); end
    rd(A_TAR, 1'b0, rv);
    checks++; if (rv !== 16'h0000) begin errors++; $display("FAIL reset_tar got=%h exp=0000", rv); end
    rd(A_CCR, 1'b0, rv);
    checks++; if (rv !== 16'h0000) begin errors++; $display("FAIL reset_ccr got=%h exp=0000", rv); end
    checks++; if (TA_IRQ !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", TA_IRQ); end
    rd(16'h0166, 1'b0, rv);
    checks++; if (rv !== 16'h0000 || periph_sel !== 1'b0) begin errors++; $display("FAIL unmapped got=%h sel=%b exp=0000 sel=0", rv, periph_sel); end
    step(1);
    rst = 1'b1;
    step(3);
    rd(A_TAR, 1'b0, rv);
    checks++; if (rv !== 16'h0000) begin errors++; $display("FAIL reset_nocount got=%h exp=0000", rv); end
    checks++; if (periph_sel !== 1'b1) begin errors++; $display("FAIL sel_tar got=%b exp=1", periph_sel); end
    bus_wr(A_CCR, 16'hBEEF, 1'b0);
    rd(A_CCR, 1'b0, rv);
    checks++; if (rv !== 16'hBEEF) begin errors++; $display("FAIL ccr_rb got=%h exp=beef", rv); end
  endtask

  task automatic test_up;
    logic [15:0] exp_tar [4];
    logic        exp_irq [4];
    exp_tar = '{16'd1, 16'd2, 16'd3, 16'd0};
    exp_irq = '{1'b0, 1'b0, 1'b0, 1'b1};
    bus_wr(A_CCR, 16'd3, 1'b0);
    bus_wr(A_CTL, 16'h0016, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1);
      rd(A_TAR, 1'b0, rv);
      checks++; if (rv !== exp_tar[i]) begin errors++; $display("FAIL up_tar[%0d] got=%h exp=%h", i, rv, exp_tar[i]); end
      checks++; if (TA_IRQ !== exp_irq[i]) begin errors++; $display("FAIL up_irq[%0d] got=%b exp=%b", i, TA_IRQ, exp_irq[i]); end
    end
    bus_wr(A_CCR, 16'd0, 1'b0);
    bus_wr(A_CTL, 16'h0014, 1'b0);
    step(3);
    rd(A_TAR, 1'b0, rv);
    checks++; if (rv !== 16'h0000) begin errors++; $display("FAIL up_ccr0_zero got=%h exp=0000", rv); end
    rd(A_CTL, 1'b0, rv);
    checks++; if (rv !== 16'h0010) begin errors++; $display("FAIL up_ccr0_zero_ctl got=%h exp=0010", rv); end
  endtask

  task automatic test_continuous;
    bus_wr(A_CTL, 16'h0000, 1'b0);
    bus_wr(A_TAR, 16'hFFFE, 1'b0);
    bus_wr(A_CTL, 16'h00A0, 1'b0);
    step(3);
    rd(A_TAR, 1'b0, rv);
    checks++; if (rv !== 16'hFFFE) begin errors++; $display("FAIL cont_e3 got=%h exp=fffe", rv); end
    step(1);
    rd(A_TAR, 1'b0, rv);
    checks++; if (rv !== 16'hFFFF) begin errors++; $display("FAIL cont_e4 got=%h exp=ffff", rv); end
    step(3);
    rd(A_TAR, 1'b0, rv);
    checks++; if (rv !== 16'hFFFF) begin errors++; $display("FAIL cont_e7 got=%h exp=ffff", rv); end
    step(1);
    rd(A_TAR, 1'b0, rv);
    checks++; if (rv !== 16'h0000) begin errors++; $display("FAIL cont_e8 got=%h exp=0000", rv); end
    rd(A_CTL, 1'b0, rv);
    checks++; if (rv !== 16'h00A1) begin errors++; $display("FAIL cont_ifg got=%h exp=00a1", rv); end
    checks++; if (TA_IRQ !== 1'b0) begin errors++; $display("FAIL cont_irq_masked got=%b exp=0", TA_IRQ); end
  endtask

  task automatic test_priority;
    step(3);
    bus_wr(A_TAR, 16'h0010, 1'b0);
    rd(A_TAR, 1'b0, rv);
    checks++; if (rv !== 16'h0010) begin errors++; $display("FAIL prio_tar got=%h exp=0010", rv); end
    step(3);
    rd(A_TAR, 1'b0, rv);
    checks++; if (rv !== 16'h0010) begin errors++; $display("FAIL prio_presc_hold got=%h exp=0010", rv); end
    step(1);
    rd(A_TAR, 1'b0, rv);
    checks++; if (rv !== 16'h0011) begin errors++; $display("FAIL prio_presc_tick got=%h exp=0011", rv); end
    bus_wr(A_CTL, 16'h0000, 1'b0);
    bus_wr(A_TAR, 16'hFFFF, 1'b0);
    bus_wr(A_CTL, 16'h0020, 1'b0);
    bus_wr(A_CTL, 16'h0020, 1'b0);
    rd(A_CTL, 1'b0, rv);
    checks++; if (rv !== 16'h0021) begin errors++; $display("FAIL prio_ifg got=%h exp=0021", rv); end
    rd(A_TAR, 1'b0, rv);
    checks++; if (rv !== 16'h0000) begin errors++; $display("FAIL prio_wrap got=%h exp=0000", rv); end
  endtask

  task automatic test_byte;
    bus_wr(A_CTL, 16'h0000, 1'b0);
    bus_wr(A_CCR, 16'h1234, 1'b0);
    bus_wr(16'h0165, 16'hA5A5, 1'b1);
    rd(A_CCR, 1'b0, rv);
    checks++; if (rv !== 16'hA534) begin errors++; $display("FAIL byte_hi_wr got=%h exp=a534", rv); end
    rd(16'h0165, 1'b1, rv);
    checks++; if (rv !== 16'h00A5) begin errors++; $display("FAIL byte_hi_rd got=%h exp=00a5", rv); end
    rd(16'h0164, 1'b1, rv);
    checks++; if (rv !== 16'h0034) begin errors++; $display("FAIL byte_lo_rd got=%h exp=0034", rv); end
    bus_wr(16'h0164, 16'h5A5A, 1'b1);
    rd(A_CCR, 1'b0, rv);
    checks++; if (rv !== 16'hA55A) begin errors++; $display("FAIL byte_lo_wr got=%h exp=a55a", rv); end
  endtask

  task automatic test_updown;
    logic [15:0] exp_tar [6];
    logic [15:0] exp_ctl [6];
`ifdef PERIPH_TIMER_UPDOWN_EN
    exp_tar = '{16'd1, 16'd2, 16'd1, 16'd0, 16'd1, 16'd2};
    exp_ctl = '{16'h0030, 16'h0030, 16'h0030, 16'h0031, 16'h0031, 16'h0031};
`else
    exp_tar = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    exp_ctl = '{16'h0030, 16'h0030, 16'h0030, 16'h0030, 16'h0030, 16'h0030};
`endif
    bus_wr(A_CCR, 16'd2, 1'b0);
    bus_wr(A_CTL, 16'h0034, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(1);
      rd(A_TAR, 1'b0, rv);
      checks++; if (rv !== exp_tar[i]) begin errors++; $display("FAIL updown_tar[%0d] got=%h exp=%h", i, rv, exp_tar[i]); end
      rd(A_CTL, 1'b0, rv);
      checks++; if (rv !== exp_ctl[i]) begin errors++; $display("FAIL updown_ctl[%0d] got=%h exp=%h", i, rv, exp_ctl[i]); end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_up();
    test_continuous();
    test_priority();
    test_byte();
    test_updown();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/periph_timer.md
# periph_timer

Memory-mapped 16-bit timer that responds to the CPU's MAB/MDB memory bus; it is the responder end of the same bus that `mem_space` serves. The block decodes `MAB_in`, accepts word or byte writes qualified by `MW`/`BW`, and drives read data plus a select flag so the read-data mux can choose between the timer and memory. A prescaled counter runs in stop, up, continuous or up/down mode and raises an interrupt request on period completion.

## Interface
- `BASE`, default 16'h0160: word-aligned base address; the block decodes `BASE`, `BASE+2` and `BASE+4`.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `MAB_in`  input  16  bus address.
- `MDB_in`  input  16  write data from the CPU.
- `MW`  input  1  write strobe, sampled on the rising edge of `clk`.
- `BW`  input  1  byte access when 1; byte lane selected by `MAB_in[0]`.
- `MDB_periph`  output  16  read data. Combinational from registers. 0 when `periph_sel`=0.
- `periph_sel`  output  1  combinational address hit on any of the 3 registers (`MAB_in[15:1]` match).
- `TA_IRQ`  output  1  `IE & IFG`, driven from registered state.

## Operation
- **CTL at `BASE+0`:**
  - [0] IFG: read/write.
  - [1] IE.
  - [2] CLR: write-only, self-clearing, always reads 0.
  - [5:4] MC: 00 stop, 01 up, 10 continuous, 11 up/down.
  - [7:6] ID: prescaler divides by 1, 2, 4 or 8.
  - [15:8]: read as 0, writes ignored.
- **TAR at `BASE+2`:** counter, read/write.
- **CCR0 at `BASE+4`:** period/compare value, read/write.
- **Byte access (`BW`=1):**
  - Writes: `MAB_in[0]`=0 updates bits [7:0]; `MAB_in[0]`=1 updates bits [15:8].
  - Reads: return the addressed byte zero-extended in [7:0].
- **Prescaler:** 3-bit counter. A tick occurs when the prescaler equals ID divisor−1; the prescaler then wraps to 0. The prescaler holds at 0 in stop mode.
- **Counting modes, on each tick:**
  - Up: if TAR==CCR0, then TAR←0 and IFG←1; otherwise TAR+1. If CCR0==0, TAR holds at 0 and IFG is not set. If TAR>CCR0 (CCR0 was written lower), TAR counts to 16'hFFFF, wraps to 0 and sets IFG.
  - Continuous: TAR+1. On the wrap 16'hFFFF→0, IFG←1.
  - Up/down: a direction flag starts at up.
    - Counting up: at TAR==CCR0 the direction flips to down and TAR decrements.
    - Counting down: at TAR==1, TAR←0 and IFG←1. At TAR==0 the direction flips to up.
    - CCR0==0: TAR holds at 0.
- **CLR write:** in the same edge, TAR←0, prescaler←0 and direction←up. The other CTL bits take the written values.
- **Write priority:**
  - A CPU write to TAR wins over a simultaneous tick, and the prescaler resets to 0.
  - A hardware IFG set wins over a simultaneous software write of IFG=0.
- **Mode change:** takes effect from the next tick. TAR is preserved unless CLR is written.

## Timing
- **Reset values** (`rst`=0, asynchronous): CTL, TAR, CCR0, prescaler and direction are all 0. Outputs: `MDB_periph`=0 when unselected, `periph_sel` follows `MAB_in`, `TA_IRQ`=0.
- **Writes:** visible on read-back from the cycle after the edge where `MW`=1 and `periph_sel`=1. The bus protocol has no wait states.
- **Reads:** zero-latency combinational path from `MAB_in` to `MDB_periph`.
- **Counter timing:** with ID divide by 1, TAR changes on every edge. With divide by N, TAR changes every N edges. The first tick comes N edges after a mode change from stop.
- **IRQ timing:** IFG rises on the same edge as the TAR wrap. `TA_IRQ` follows in the same cycle, since it is a function of registered bits.
- **Reset mid-operation:** all state clears immediately, and counting resumes only after software reprograms MC.

## Configuration
- `PERIPH_TIMER_UPDOWN_EN`:
  - Defined: MC=11 is up/down as above.
  - Undefined: the direction logic is removed and MC=11 behaves as stop. The MC field still reads back the written value.

## Test plan
- **Reset and read-back:** assert `rst`=0 mid-count with TAR=16'h1234, then release. All reads return 0 and `TA_IRQ`=0. Write CCR0=16'hBEEF and read back 16'hBEEF.
- **Up mode:** CCR0=3, ID=÷1, IE=1, MC=01. TAR sequence is 1,2,3,0. IFG and `TA_IRQ` go to 1 on the edge where TAR returns to 0.
- **Continuous mode:** TAR=16'hFFFE, ID=÷4. TAR reaches 16'hFFFF after 4 edges and 0 after 8 edges. IFG=1 at the wrap.
- **Up/down mode** (macro defined): CCR0=2. TAR sequence is 1,2,1,0,1,2. IFG sets only at the 1→0 step.
- **Byte access:** byte write 8'hA5 to `BASE+5` leaves CCR0[7:0] unchanged and sets CCR0[15:8]=8'hA5. A byte read of `BASE+5` returns 16'h00A5.
- **Priority:** write TAR=16'h0010 on a tick edge, and TAR reads 16'h0010. Software writes IFG=0 on the wrap edge, and IFG stays 1.
